// File: rtl/key_event_scheduler.sv
// Round-robin key arbiter: latches button pulses, queues grants in a small FIFO
// and issues one-hot key pulses separated by a gap. Optional counters: KEY_SCHED_STATS_EN.
module key_event_scheduler #(
  parameter int unsigned NUM_KEYS   = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_KEYS-1:0]             key_pulse,
  input  logic                            hold,
  input  logic                            clr_drop,
  output logic [NUM_KEYS-1:0]             key_out,
  output logic                            busy,
  output logic                            drop_flag,
`ifdef KEY_SCHED_STATS_EN
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [7:0]                      issued_cnt,
  output logic [7:0]                      drop_cnt
`else
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
`endif
);

  localparam int unsigned IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [IW-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  state_t              state_q;
  logic [7:0]          gap_q;
  logic                drop_flag_q;

  logic                grant_vld;
  logic [IW-1:0]       grant_idx;
  logic [NUM_KEYS-1:0] grant_oh;
  logic                fifo_full;
  logic                push, pop, drop, avail;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    return IW'(s % NUM_KEYS);
  endfunction

  assign fifo_full = (count_q == FULL_CNT);

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    if (!fifo_full) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (!grant_vld && pending_q[wrap_idx(rr_q, k)]) begin
          grant_vld = 1'b1;
          grant_idx = wrap_idx(rr_q, k);
        end
      end
    end
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
    rr_d = grant_vld ? wrap_idx(grant_idx, 1) : rr_q;
  end

  // Grant clears first, then a same-cycle pulse re-arms the latch without a drop.
  assign pending_d = (pending_q & ~grant_oh) | key_pulse;
  assign drop      = |(key_pulse & pending_q & ~grant_oh);

  assign push    = grant_vld;
  assign pop     = (state_q == S_ISSUE);
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign avail   = (count_q != '0) || grant_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      rr_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_flag_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (drop)          drop_flag_q <= 1'b1;
      else if (clr_drop) drop_flag_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= grant_idx;
  end

  // An entry granted this cycle lands in the FIFO on the same edge the FSM
  // enters ISSUE, so IDLE and the final GAP cycle both look ahead at the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (avail && !hold) state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          gap_q   <= 8'(GAP_CYCLES);
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (gap_q <= 8'd1) begin
            gap_q   <= '0;
            state_q <= (avail && !hold) ? S_ISSUE : S_IDLE;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign key_out    = (state_q == S_ISSUE) ? (NUM_KEYS'(1) << mem_q[rd_ptr_q]) : '0;
  assign busy       = (|pending_q) || (count_q != '0) || (state_q != S_IDLE);
  assign drop_flag  = drop_flag_q;
  assign fifo_count = count_q;

`ifdef KEY_SCHED_STATS_EN
  logic [7:0] issued_q, dropc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      dropc_q  <= '0;
    end else begin
      if (state_q == S_ISSUE && issued_q != 8'hFF) issued_q <= issued_q + 8'd1;
      if (clr_drop)                       dropc_q <= drop ? 8'd1 : 8'd0;
      else if (drop && dropc_q != 8'hFF)  dropc_q <= dropc_q + 8'd1;
    end
  end

  assign issued_cnt = issued_q;
  assign drop_cnt   = dropc_q;
`endif

endmodule

// File: tb/tb_key_event_scheduler.sv
// Scoreboard bench for key_event_scheduler: expected keys are queued at stimulus
// time and matched against key_out pulses by a negedge monitor.
module tb_key_event_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_pulse = '0;
  logic       hold = 1'b0;
  logic       clr_drop = 1'b0;
  logic [3:0] key_out;
  logic       busy;
  logic       drop_flag;
  logic [2:0] fifo_count;

  typedef struct {
    logic [3:0] key;
    int         cyc;   // -1 = issue time not checked
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  key_event_scheduler #(.NUM_KEYS(4), .FIFO_DEPTH(4), .GAP_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_pulse  (key_pulse),
    .hold       (hold),
    .clr_drop   (clr_drop),
    .key_out    (key_out),
    .busy       (busy),
    .drop_flag  (drop_flag),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (key_out !== 4'b0000) begin
      if (q.size() == 0) begin
        check("unexpected_key", {28'd0, key_out}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("key_out", {28'd0, key_out}, {28'd0, e.key});
        if (e.cyc >= 0) check("key_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic press(input logic [3:0] k);
    key_pulse = k;
    @(negedge clk);
    key_pulse = '0;
  endtask

  task automatic expect_key(input logic [3:0] k, input int c);
    exp_t e;
    e.key = k;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", {31'd0, n < maxc}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    repeat (2) @(negedge clk);
    check("rst_key_out", {28'd0, key_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_drop", {31'd0, drop_flag}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    int t0;
    do_reset();

    // Single press
    repeat (3) @(negedge clk);
    t0 = cyc;
    expect_key(4'b0100, t0 + 2);
    press(4'b0100);
    check("single_busy_early", {31'd0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    check("single_busy_gap_end", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("single_busy_low", {31'd0, busy}, 32'd0);
    check("single_drop", {31'd0, drop_flag}, 32'd0);
    drain(50);

    // Simultaneous press, rr = 0
    do_reset();
    t0 = cyc;
    expect_key(4'b0001, t0 + 2);
    expect_key(4'b0010, t0 + 11);
    expect_key(4'b0100, t0 + 20);
    expect_key(4'b1000, t0 + 29);
    press(4'b1111);
    repeat (4) @(negedge clk);
    check("simul_count", {29'd0, fifo_count}, 32'd3);
    drain(100);
    check("simul_drop", {31'd0, drop_flag}, 32'd0);

    // Fairness: key1 moves rr to 2, then {0,2,3} -> 2,3,0
    t0 = cyc;
    expect_key(4'b0010, t0 + 2);
    press(4'b0010);
    drain(50);
    t0 = cyc;
    expect_key(4'b0100, t0 + 2);
    expect_key(4'b1000, t0 + 11);
    expect_key(4'b0001, t0 + 20);
    press(4'b1101);
    drain(100);

    // Same-key pulse while its latch is being granted: no drop
    hold = 1'b1;
    press(4'b0100);
    press(4'b0100);
    @(negedge clk);
    check("regrant_count", {29'd0, fifo_count}, 32'd2);
    check("regrant_drop", {31'd0, drop_flag}, 32'd0);
    expect_key(4'b0100, -1);
    expect_key(4'b0100, -1);
    hold = 1'b0;
    drain(100);

    // Overflow under hold
    hold = 1'b1;
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    press(4'b1000);
    @(negedge clk);
    check("ovf_full", {29'd0, fifo_count}, 32'd4);
    press(4'b0001);
    @(negedge clk);
    check("ovf_first_extra", {31'd0, drop_flag}, 32'd0);
    press(4'b0001);
    check("ovf_drop", {31'd0, drop_flag}, 32'd1);
    clr_drop = 1'b1;
    press(4'b0001);
    clr_drop = 1'b0;
    check("ovf_set_wins", {31'd0, drop_flag}, 32'd1);
    check("ovf_count", {29'd0, fifo_count}, 32'd4);
    repeat (5) @(negedge clk);
    check("ovf_hold_idle", {28'd0, key_out}, 32'd0);
    expect_key(4'b0001, -1);
    expect_key(4'b0010, -1);
    expect_key(4'b0100, -1);
    expect_key(4'b1000, -1);
    expect_key(4'b0001, -1);
    hold = 1'b0;
    drain(200);
    check("ovf_sticky", {31'd0, drop_flag}, 32'd1);
    clr_drop = 1'b1;
    @(negedge clk);
    clr_drop = 1'b0;
    check("ovf_cleared", {31'd0, drop_flag}, 32'd0);

    // Reset during GAP with two entries queued
    do_reset();
    t0 = cyc;
    expect_key(4'b0001, t0 + 2);
    press(4'b1111);
    repeat (3) @(negedge clk);
    check("mid_count", {29'd0, fifo_count}, 32'd2);
    check("mid_q_popped", q.size(), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_key", {28'd0, key_out}, 32'd0);
    check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_no_stale_busy", {31'd0, busy}, 32'd0);
    check("sb_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
